// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Issues one word-aligned request at a time to the
// instruction memory, holds the fetched word for decode until it is consumed,
// and follows branch/jump redirects. A fetch that is still outstanding when a
// redirect arrives is allowed to complete and its word is thrown away.
//
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   imem_req_o       : fetch request to instruction memory
//   imem_addr_o      : word-aligned fetch address, valid while imem_req_o=1
//   imem_ack_i       : memory accepted request, imem_rdata_i valid same cycle
//   imem_rdata_i     : fetched instruction word
//   instr_valid_o    : instr_o/instr_pc_o hold an instruction for decode
//   instr_o          : instruction word
//   instr_pc_o       : address of instr_o
//   instr_ready_i    : decode consumes instr_o when instr_valid_o=1
//   redirect_valid_i : one-cycle request to change the fetch PC
//   redirect_pc_i    : new PC, bits [1:0] ignored
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic        hs_s;
  logic [31:0] redir_al_s;

  // An ack only counts while a request is actually on the bus, so an ack seen
  // in the first cycle after reset (request not yet raised) is ignored.
  assign hs_s       = req_q & imem_ack_i;
  assign redir_al_s = redirect_pc_i & 32'hFFFF_FFFC;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC_AL;
      target_q   <= 32'h0000_0000;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    req_d      = req_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      S_FETCH: begin
        if (redirect_valid_i) begin
          if (hs_s || !req_q) begin
            // Nothing left outstanding: retarget directly.
            pc_d  = redir_al_s;
            req_d = 1'b1;
          end else begin
            // Request in flight: keep it on the bus, remember the target.
            target_d = redir_al_s;
            state_d  = S_DISCARD;
            req_d    = 1'b1;
          end
        end else if (hs_s) begin
          instr_d    = imem_rdata_i;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;   // wraps modulo 2^32
          valid_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = S_HOLD;
        end else begin
          req_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid_i) begin
          // Held word is dropped even if decode is ready this cycle.
          valid_d = 1'b0;
          pc_d    = redir_al_s;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (instr_ready_i) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          valid_d = 1'b1;
          req_d   = 1'b0;
        end
      end

      S_DISCARD: begin
        if (hs_s) begin
          // Old-path word arrives and is thrown away; newest target wins.
          if (redirect_valid_i) begin
            pc_d = redir_al_s;
          end else begin
            pc_d = target_q;
          end
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (redirect_valid_i) begin
          target_d = redir_al_s;
        end else begin
          req_d = 1'b1;
        end
      end

      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule
